// File: rtl/seq_shifter_if.sv
// Handshake and data bundle between a shift requester and seq_shifter.
// The requester owns start/op/operands; the shifter owns status and result.
interface seq_shifter_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] data_in;
    logic [31:0] shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        carry_out;

    modport master (
        output start,
        output op,
        output data_in,
        output shamt,
        input  busy,
        input  done,
        input  result,
        input  carry_out
    );

    modport slave (
        input  start,
        input  op,
        input  data_in,
        input  shamt,
        output busy,
        output done,
        output result,
        output carry_out
    );
endinterface

// File: rtl/seq_shifter.sv
// Iterative 32-bit shifter: one bit position per clock, with SLL/SRL/SRA/ROR
// and a carry_out holding the last bit shifted or rotated out.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for start; result/carry_out hold the previous answer
// ST_SHIFT | one shift step per clock, count down to terminal count of 1
// ST_DONE  | done pulse for one cycle, then back to ST_IDLE unconditionally
module seq_shifter (
    input  logic         clk,
    input  logic         rst,
    seq_shifter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    state_t      state_q, state_d;
    logic [31:0] work_q,  work_d;
    logic [1:0]  op_q,    op_d;
    logic [4:0]  count_q, count_d;
    logic        carry_q, carry_d;
    logic [4:0]  shamt_lo;
    logic [32:0] step_out;
    logic        unused_shamt_hi;

    // Only a 5-bit amount is meaningful; the upper source bits are dropped.
    assign shamt_lo        = bus.shamt[4:0];
    assign unused_shamt_hi = ^bus.shamt[31:5];

    // One shift step; returns {bit shifted out, new working value}.
    function automatic logic [32:0] shift_step(input logic [1:0] op, input logic [31:0] v);
        case (op)
            OP_SLL:  shift_step = {v[31], v[30:0], 1'b0};
            OP_SRL:  shift_step = {v[0], 1'b0, v[31:1]};
            OP_SRA:  shift_step = {v[0], v[31], v[31:1]};
            default: shift_step = {v[0], v[0], v[31:1]};
        endcase
    endfunction

    assign step_out = shift_step(op_q, work_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            op_q    <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            op_q    <= op_d;
            count_q <= count_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        op_d    = op_q;
        count_d = count_q;
        carry_d = carry_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    work_d  = bus.data_in;
                    op_d    = bus.op;
                    count_d = shamt_lo;
                    carry_d = 1'b0;
                    state_d = (shamt_lo == 5'd0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                carry_d = step_out[32];
                work_d  = step_out[31:0];
                count_d = count_q - 5'd1;
                if (count_q == 5'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.result    = work_q;
    assign bus.carry_out = carry_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: vector table of shift operations plus
// hand sequences for ignored start, back-to-back acceptance and mid-op reset.
module tb_seq_shifter;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    seq_shifter_if bus();

    seq_shifter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [31:0] shamt;
        logic [31:0] exp_res;
        logic        exp_c;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called one step after an edge; returns the cycle index in which done was seen.
    task automatic wait_done(output int lat, output logic busy_ok);
        lat     = -1;
        busy_ok = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.done === 1'b1) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic run_op(input int idx, input vec_t v);
        int   lat;
        logic bok;
        bus.start   = 1'b1;
        bus.op      = v.op;
        bus.data_in = v.data;
        bus.shamt   = v.shamt;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.op      = ~v.op;
        bus.data_in = ~v.data;
        bus.shamt   = v.shamt + 32'd3;
        wait_done(lat, bok);
        check($sformatf("v%0d latency", idx), lat, v.exp_lat);
        check($sformatf("v%0d result", idx), bus.result, v.exp_res);
        check($sformatf("v%0d carry", idx), bus.carry_out, v.exp_c);
        check($sformatf("v%0d busy_during", idx), bok, 1'b1);
        @(posedge clk); #1;
        check($sformatf("v%0d done_pulse", idx), bus.done, 1'b0);
        check($sformatf("v%0d busy_after", idx), bus.busy, 1'b0);
        check($sformatf("v%0d result_hold", idx), bus.result, v.exp_res);
        check($sformatf("v%0d carry_hold", idx), bus.carry_out, v.exp_c);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int   lat;
        logic bok;
        logic seen;

        vecs[0]  = '{2'b00, 32'h0000_0001, 32'd4,          32'h0000_0010, 1'b0, 5};
        vecs[1]  = '{2'b10, 32'h8000_0000, 32'd31,         32'hFFFF_FFFF, 1'b0, 32};
        vecs[2]  = '{2'b01, 32'h8000_0000, 32'd31,         32'h0000_0001, 1'b0, 32};
        vecs[3]  = '{2'b01, 32'h8000_0001, 32'd1,          32'h4000_0000, 1'b1, 2};
        vecs[4]  = '{2'b00, 32'h1234_5678, 32'h0000_0020,  32'h1234_5678, 1'b0, 1};
        vecs[5]  = '{2'b11, 32'h0000_0001, 32'd1,          32'h8000_0000, 1'b1, 2};
        vecs[6]  = '{2'b00, 32'h8000_0001, 32'd1,          32'h0000_0002, 1'b1, 2};
        vecs[7]  = '{2'b11, 32'h1234_5678, 32'd4,          32'h8123_4567, 1'b1, 5};
        vecs[8]  = '{2'b10, 32'hF000_0000, 32'hFFFF_FFE4,  32'hFF00_0000, 1'b0, 5};
        vecs[9]  = '{2'b00, 32'hFFFF_FFFF, 32'd31,         32'h8000_0000, 1'b1, 32};
        vecs[10] = '{2'b11, 32'h0000_000F, 32'd2,          32'hC000_0003, 1'b1, 3};
        vecs[11] = '{2'b01, 32'h0000_000A, 32'd3,          32'h0000_0001, 1'b0, 4};

        rst         = 1'b1;
        bus.start   = 1'b1;
        bus.op      = 2'b00;
        bus.data_in = 32'hFFFF_FFFF;
        bus.shamt   = 32'd5;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", bus.busy, 1'b0);
        check("reset done", bus.done, 1'b0);
        check("reset result", bus.result, 32'h0);
        check("reset carry", bus.carry_out, 1'b0);

        // First edge with rst low accepts immediately.
        rst = 1'b0;
        for (int i = 0; i < 12; i++) run_op(i, vecs[i]);

        // Start held high through SHIFT and DONE must not disturb the ROR.
        bus.start   = 1'b1;
        bus.op      = 2'b11;
        bus.data_in = 32'h0000_0001;
        bus.shamt   = 32'd1;
        @(posedge clk); #1;
        bus.op      = 2'b00;
        bus.data_in = 32'hDEAD_BEEF;
        bus.shamt   = 32'd7;
        check("ign shift busy", bus.busy, 1'b1);
        @(posedge clk); #1;
        check("ign done", bus.done, 1'b1);
        check("ign result", bus.result, 32'h8000_0000);
        check("ign carry", bus.carry_out, 1'b1);
        @(posedge clk); #1;
        check("dead cycle busy", bus.busy, 1'b0);
        check("dead cycle done", bus.done, 1'b0);
        check("dead cycle result", bus.result, 32'h8000_0000);
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.data_in = 32'h0;
        bus.shamt   = 32'd0;
        wait_done(lat, bok);
        check("b2b latency", lat, 32'd8);
        check("b2b result", bus.result, 32'h56DF_7780);
        check("b2b carry", bus.carry_out, 1'b1);
        check("b2b busy_during", bok, 1'b1);
        @(posedge clk); #1;

        // Reset in the third SHIFT cycle of SLL by 10.
        bus.start   = 1'b1;
        bus.op      = 2'b00;
        bus.data_in = 32'h0000_0001;
        bus.shamt   = 32'd10;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort pre result", bus.result, 32'h0000_0004);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort busy", bus.busy, 1'b0);
        check("abort result", bus.result, 32'h0);
        check("abort carry", bus.carry_out, 1'b0);
        check("abort done", bus.done, 1'b0);
        seen = 1'b0;
        repeat (15) begin
            if (bus.done === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("abort no_done", seen, 1'b0);
        run_op(12, '{2'b00, 32'h0000_0003, 32'd2, 32'h0000_000C, 1'b0, 3});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
